// File: rtl/fetch_inst_queue.sv
// Dual-issue fetch->decode instruction queue. A bundle accepted at an edge is visible on instA/instB right after it.
// Backpressure: fetch_ready only while two entries are free; the decoder holds entries in place via errorA/errorB.
module fetch_inst_queue #(
  parameter int          DEPTH = 8,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_validA,
  input  logic        fetch_validB,
  input  logic [31:0] fetch_instA,
  input  logic [31:0] fetch_instB,
  input  logic [31:0] fetch_pcA,
  input  logic [31:0] fetch_pcB,
  output logic        fetch_ready,
  input  logic        flush,
  input  logic        errorA,
  input  logic        errorB,
  output logic [31:0] instA,
  output logic [31:0] instB,
  output logic [31:0] pcA,
  output logic [31:0] pcB,
  output logic        validA,
  output logic        validB,
  output logic [15:0] stall_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [AW-1:0] head_nxt1;
  logic [AW-1:0] tail_nxt1;
  logic          eff_errA;
  logic          eff_errB;
  logic [1:0]    n_in;
  logic [1:0]    n_out;

  // Power-of-two depth lets pointer arithmetic wrap for free.
  assign head_nxt1 = head + AW'(1);
  assign tail_nxt1 = tail + AW'(1);

  assign validA      = (count != '0);
  assign validB      = (count >= CW'(2));
  assign fetch_ready = (count <= CW'(DEPTH - 2));

  assign instA = validA ? mem[head].inst      : NOP;
  assign pcA   = validA ? mem[head].pc        : 32'd0;
  assign instB = validB ? mem[head_nxt1].inst : NOP;
  assign pcB   = validB ? mem[head_nxt1].pc   : 32'd0;

  assign eff_errA = errorA & validA;
  assign eff_errB = errorB & validB;

  always_comb begin
    n_in = 2'd0;
    if (fetch_ready && fetch_validA)
      n_in = fetch_validB ? 2'd2 : 2'd1;
  end

  // An error on A blocks B too, so retirement stays strictly in order.
  always_comb begin
    n_out = 2'd0;
    if (validA && !eff_errA)
      n_out = (validB && !eff_errB) ? 2'd2 : 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      stall_cnt <= 16'd0;
    end else begin
      if (eff_errA && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        head  <= head + AW'(n_out);
        tail  <= tail + AW'(n_in);
        count <= count + CW'(n_in) - CW'(n_out);
      end
    end
  end

  // Storage carries no reset; occupancy masks stale contents.
  always_ff @(posedge clk) begin
    if (!flush && n_in != 2'd0)
      mem[tail] <= '{inst: fetch_instA, pc: fetch_pcA};
    if (!flush && n_in == 2'd2)
      mem[tail_nxt1] <= '{inst: fetch_instB, pc: fetch_pcB};
  end

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Directed stimulus for fetch_inst_queue with an in-order retirement scoreboard.
module tb_fetch_inst_queue;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_validA = 1'b0;
  logic        fetch_validB = 1'b0;
  logic [31:0] fetch_instA = 32'd0;
  logic [31:0] fetch_instB = 32'd0;
  logic [31:0] fetch_pcA = 32'd0;
  logic [31:0] fetch_pcB = 32'd0;
  logic        fetch_ready;
  logic        flush = 1'b0;
  logic        errorA = 1'b0;
  logic        errorB = 1'b0;
  logic [31:0] instA, instB, pcA, pcB;
  logic        validA, validB;
  logic [15:0] stall_cnt;

  int   checks = 0;
  int   errors = 0;
  ent_t exp_q[$];

  fetch_inst_queue #(.DEPTH(8), .NOP(NOP)) dut (
    .clk(clk), .rst(rst),
    .fetch_validA(fetch_validA), .fetch_validB(fetch_validB),
    .fetch_instA(fetch_instA), .fetch_instB(fetch_instB),
    .fetch_pcA(fetch_pcA), .fetch_pcB(fetch_pcB),
    .fetch_ready(fetch_ready), .flush(flush),
    .errorA(errorA), .errorB(errorB),
    .instA(instA), .instB(instB), .pcA(pcA), .pcB(pcB),
    .validA(validA), .validB(validB), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  function automatic void chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] ins(input logic [31:0] base, input int k);
    return base + 32'(k);
  endfunction

  function automatic logic [31:0] pcv(input logic [31:0] base, input int k);
    return base + 32'(4 * k);
  endfunction

  // Drive one cycle of inputs just after the edge; push the entries the bench expects to be accepted.
  task automatic tick(input logic va, input logic vb, input logic [31:0] ia, input logic [31:0] pa,
                      input logic [31:0] ib, input logic [31:0] pb,
                      input logic ea, input logic eb, input logic fl, input int push);
    @(posedge clk);
    #1;
    fetch_validA = va;
    fetch_validB = vb;
    fetch_instA  = ia;
    fetch_pcA    = pa;
    fetch_instB  = ib;
    fetch_pcB    = pb;
    errorA       = ea;
    errorB       = eb;
    flush        = fl;
    if (push >= 1) exp_q.push_back('{inst: ia, pc: pa});
    if (push == 2) exp_q.push_back('{inst: ib, pc: pb});
    @(negedge clk);
  endtask

  task automatic idle(input logic ea, input logic eb);
    tick(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, ea, eb, 1'b0, 0);
  endtask

  // Monitor: compare presented slots with the oldest expected entries and retire what the decoder accepts.
  always @(negedge clk) begin
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (validA) begin
        if (exp_q.size() < 1) begin
          checks++; errors++;
          $display("FAIL sb_slotA unexpected instA=%h expected=<none>", instA);
        end else begin
          chk("sb_instA", instA, exp_q[0].inst);
          chk("sb_pcA", pcA, exp_q[0].pc);
        end
      end
      if (validB) begin
        if (exp_q.size() < 2) begin
          checks++; errors++;
          $display("FAIL sb_slotB unexpected instB=%h expected=<none>", instB);
        end else begin
          chk("sb_instB", instB, exp_q[1].inst);
          chk("sb_pcB", pcB, exp_q[1].pc);
        end
      end
      if (validA && !errorA && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        if (validB && !errorB && exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk1("rst_validA", validA, 1'b0);
    chk1("rst_validB", validB, 1'b0);
    chk("rst_instA", instA, NOP);
    chk("rst_instB", instB, NOP);
    chk("rst_pcA", pcA, 32'd0);
    chk("rst_pcB", pcB, 32'd0);
    chk1("rst_ready", fetch_ready, 1'b1);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    #2 rst = 1'b0;

    // Single bundle pass-through
    tick(1'b1, 1'b1, 32'h00500093, 32'h0, 32'h00A00113, 32'h4, 1'b0, 1'b0, 1'b0, 2);
    chk1("t1_empty_validA", validA, 1'b0);
    idle(1'b0, 1'b0);
    chk1("t1_validA", validA, 1'b1);
    chk1("t1_validB", validB, 1'b1);
    chk("t1_instA", instA, 32'h00500093);
    chk("t1_instB", instB, 32'h00A00113);
    idle(1'b0, 1'b0);
    chk1("t1_drained_validA", validA, 1'b0);
    chk("t1_drained_instA", instA, NOP);
    chk("t1_drained_instB", instB, NOP);
    chk("t1_drained_pcA", pcA, 32'd0);

    // Fill with errorA held: 1 then 2 per cycle up to count 7
    tick(1'b1, 1'b0, ins(32'h10000000, 0), pcv(32'h100, 0), 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1);
    chk("fill_stall0", 32'(stall_cnt), 32'd0);
    tick(1'b1, 1'b1, ins(32'h10000000, 1), pcv(32'h100, 1), ins(32'h10000000, 2), pcv(32'h100, 2), 1'b1, 1'b0, 1'b0, 2);
    chk1("fill_c1_validB", validB, 1'b0);
    chk("fill_c1_instA", instA, ins(32'h10000000, 0));
    chk("fill_c1_stall", 32'(stall_cnt), 32'd0);
    tick(1'b1, 1'b1, ins(32'h10000000, 3), pcv(32'h100, 3), ins(32'h10000000, 4), pcv(32'h100, 4), 1'b1, 1'b0, 1'b0, 2);
    chk("fill_c3_stall", 32'(stall_cnt), 32'd1);
    chk1("fill_c3_ready", fetch_ready, 1'b1);
    tick(1'b1, 1'b1, ins(32'h10000000, 5), pcv(32'h100, 5), ins(32'h10000000, 6), pcv(32'h100, 6), 1'b1, 1'b0, 1'b0, 2);
    chk("fill_c5_stall", 32'(stall_cnt), 32'd2);
    chk1("fill_c5_ready", fetch_ready, 1'b1);
    tick(1'b1, 1'b1, ins(32'h10000000, 7), pcv(32'h100, 7), ins(32'h10000000, 8), pcv(32'h100, 8), 1'b1, 1'b0, 1'b0, 0);
    chk1("fill_c7_ready", fetch_ready, 1'b0);
    chk("fill_c7_stall", 32'(stall_cnt), 32'd3);
    chk("fill_c7_instA", instA, ins(32'h10000000, 0));
    tick(1'b1, 1'b1, ins(32'h10000000, 7), pcv(32'h100, 7), ins(32'h10000000, 8), pcv(32'h100, 8), 1'b1, 1'b0, 1'b0, 0);
    chk1("fill_hold_ready", fetch_ready, 1'b0);
    chk("fill_hold_stall", 32'(stall_cnt), 32'd4);
    idle(1'b0, 1'b0);
    chk1("drain_c7_ready", fetch_ready, 1'b0);
    chk("drain_stall", 32'(stall_cnt), 32'd5);
    idle(1'b0, 1'b0);
    chk1("drain_c5_ready", fetch_ready, 1'b1);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b1);
    chk1("drain_c1_validB", validB, 1'b0);
    chk("drain_c1_instB", instB, NOP);
    chk("drain_c1_pcB", pcB, 32'd0);
    idle(1'b0, 1'b0);
    chk1("drain_empty", validA, 1'b0);
    chk("drain_stall_kept", 32'(stall_cnt), 32'd5);

    // errorB only with three queued, then errorA holding B
    tick(1'b1, 1'b1, ins(32'h0AB00000, 0), pcv(32'h400, 0), ins(32'h0AB00000, 1), pcv(32'h400, 1), 1'b0, 1'b0, 1'b0, 2);
    tick(1'b1, 1'b0, ins(32'h0AB00000, 2), pcv(32'h400, 2), 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1);
    idle(1'b0, 1'b1);
    chk("eb_pre_instA", instA, ins(32'h0AB00000, 0));
    chk("eb_pre_stall", 32'(stall_cnt), 32'd6);
    idle(1'b1, 1'b0);
    chk("eb_post_instA", instA, ins(32'h0AB00000, 1));
    chk("eb_post_instB", instB, ins(32'h0AB00000, 2));
    chk1("eb_post_validB", validB, 1'b1);
    idle(1'b0, 1'b0);
    chk("ea_hold_instA", instA, ins(32'h0AB00000, 1));
    chk("ea_hold_instB", instB, ins(32'h0AB00000, 2));
    chk("ea_hold_stall", 32'(stall_cnt), 32'd7);
    idle(1'b0, 1'b0);
    chk1("eb_empty", validA, 1'b0);

    // Steady state: enqueue 2 / dequeue 2 at count 4 for 20 cycles
    tick(1'b1, 1'b1, ins(32'h0C000000, 0), pcv(32'h2000, 0), ins(32'h0C000000, 1), pcv(32'h2000, 1), 1'b0, 1'b0, 1'b0, 2);
    tick(1'b1, 1'b1, ins(32'h0C000000, 2), pcv(32'h2000, 2), ins(32'h0C000000, 3), pcv(32'h2000, 3), 1'b1, 1'b0, 1'b0, 2);
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b1, ins(32'h0C000000, 4 + 2 * i), pcv(32'h2000, 4 + 2 * i),
           ins(32'h0C000000, 5 + 2 * i), pcv(32'h2000, 5 + 2 * i), 1'b0, 1'b0, 1'b0, 2);
      chk("ss_pcA_step", pcA, 32'h2000 + 32'(8 * i));
      chk1("ss_validB", validB, 1'b1);
      chk1("ss_ready", fetch_ready, 1'b1);
    end
    idle(1'b0, 1'b0);
    chk("ss_tail_pcA", pcA, 32'h20A0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    chk1("ss_empty", validA, 1'b0);
    chk("ss_stall", 32'(stall_cnt), 32'd8);

    // Flush with a concurrent fetch and a 2-dequeue
    tick(1'b1, 1'b1, ins(32'h0F000000, 0), pcv(32'h3000, 0), ins(32'h0F000000, 1), pcv(32'h3000, 1), 1'b0, 1'b0, 1'b0, 2);
    tick(1'b1, 1'b1, ins(32'h0F000000, 2), pcv(32'h3000, 2), ins(32'h0F000000, 3), pcv(32'h3000, 3), 1'b0, 1'b0, 1'b1, 0);
    chk1("fl_pre_validA", validA, 1'b1);
    idle(1'b0, 1'b0);
    chk1("fl_validA", validA, 1'b0);
    chk1("fl_validB", validB, 1'b0);
    chk("fl_instA", instA, NOP);
    chk1("fl_ready", fetch_ready, 1'b1);
    chk("fl_stall_kept", 32'(stall_cnt), 32'd8);
    idle(1'b0, 1'b0);
    chk1("fl_never_appears", validA, 1'b0);

    // stall_cnt saturation
    tick(1'b1, 1'b0, 32'h00001111, 32'h4000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1);
    force dut.stall_cnt = 16'hFFFE;
    #1 release dut.stall_cnt;
    idle(1'b1, 1'b0);
    chk("sat_start", 32'(stall_cnt), 32'h0000FFFE);
    idle(1'b1, 1'b0);
    chk("sat_first", 32'(stall_cnt), 32'h0000FFFF);
    idle(1'b1, 1'b0);
    chk("sat_hold1", 32'(stall_cnt), 32'h0000FFFF);
    idle(1'b0, 1'b0);
    chk("sat_hold2", 32'(stall_cnt), 32'h0000FFFF);
    idle(1'b0, 1'b0);
    chk1("sat_empty", validA, 1'b0);

    // Asynchronous reset mid-operation
    tick(1'b1, 1'b1, 32'h00002222, 32'h5000, 32'h00003333, 32'h5004, 1'b0, 1'b0, 1'b0, 2);
    idle(1'b1, 1'b0);
    chk1("ar_pre_validA", validA, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("ar_validA", validA, 1'b0);
    chk1("ar_validB", validB, 1'b0);
    chk("ar_instA", instA, NOP);
    chk1("ar_ready", fetch_ready, 1'b1);
    chk("ar_stall", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    idle(1'b0, 1'b0);
    chk1("ar_post_validA", validA, 1'b0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
